heap_priority_queue: RTL and testbench
======================================

Name: heap_priority_queue

Overview:
- Single-clock binary min-heap priority queue holding up to 31 unsigned 32-bit keys.
- Each enabled cycle performs one command: insert, extract-root or replace-root. Every command completes in one clock, so sift-up and sift-down are combinational across all levels.
- The full heap storage and the occupancy count are exposed every cycle for observation and debug by the surrounding datapath.

Parameters:
- WIDTH, 32, key width in bits (unsigned compare).
- SIZE_W, 5, width of heap_size. The array has 2**SIZE_W slots; capacity is 2**SIZE_W-1 = 31 keys.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  command qualifier; 0 = hold all state.
- operation  input  5  command code: 0 NOP, 1 INSERT, 2 EXTRACT, 3 REPLACE, 4..31 NOP.
- input_value  input  WIDTH  key for INSERT/REPLACE.
- heap_array  output  (2**SIZE_W)*WIDTH  flattened storage; slot i = bits [i*WIDTH +: WIDTH]; slot 0 = root.
- heap_size  output  SIZE_W  number of valid keys, 0..31.
- full  output  1  heap_size == 31, combinational from state.
- empty  output  1  heap_size == 0, combinational from state.
- error  output  1  registered one-cycle pulse on an illegal command.

Behaviour:
- Reset (reset==0, async): all slots = 0, heap_size = 0, error = 0. Reset overrides any command in flight; there is no partial update.
- Registered outputs change only on a rising clk edge with enable==1. When enable==0 all state holds and error = 0.
- Heap property: parent <= child, unsigned. Children of slot i are slots 2i+1 and 2i+2; the parent is (i-1)/2. Slots >= heap_size always read 0.
- INSERT, not full:
  - Place input_value at slot heap_size.
  - Sift up: swap with the parent while key < parent (strict; stop on equal).
  - heap_size + 1.
- INSERT when full: no state change; error pulses.
- EXTRACT, not empty:
  - Move slot heap_size-1 into the root and clear slot heap_size-1 to 0.
  - heap_size - 1.
  - Sift down: pick the smaller child (left on tie); swap only if that child < current key.
  - The removed root is not output; readers sample heap_array[0] before issuing EXTRACT.
- EXTRACT when empty: no change; error pulses.
- REPLACE, not empty: root = input_value, then sift down as for EXTRACT; heap_size unchanged.
- REPLACE when empty: behaves exactly as INSERT, no error.
- Latency: result visible in heap_array and heap_size one clock after the command edge. A new command is accepted every cycle; there are no back-to-back hazards.
- Sift logic is combinational from the current registers: at most SIZE_W levels for sift-up, SIZE_W-1 levels for sift-down.

Optional Feature:
- Macro HEAP_MAX_EN.
- Defined: max-heap. Parent >= child; sift-up swaps while key > parent; sift-down picks the larger child (left on tie) and swaps only if child > key.
- Undefined: min-heap exactly as specified above.
- Full/empty/error behaviour is identical in both builds.

Test Plan:
- Reset low mid-stream, then high -> heap_size=0, every slot 0, empty=1, error=0.
- INSERT 15,10,20,5,30 on consecutive cycles -> heap_array[0..4] = 5,10,20,15,30; heap_size=5.
- Then EXTRACT -> slots 0..3 = 10,15,20,30; slot 4 = 0; heap_size=4.
- Then REPLACE with 30 -> slots 0..3 = 15,30,20,30; heap_size=4. Then enable=0 for 5 cycles -> unchanged.
- EXTRACT on empty heap -> error high for exactly one cycle, heap_size stays 0. 31 INSERTs then a 32nd -> full=1, error pulse, contents unchanged.
- HEAP_MAX_EN build, INSERT 15,10,20,5,30 -> slots 0..4 = 30,20,15,5,10; EXTRACT -> slots 0..3 = 20,10,15,5.

Source files
------------

// File: rtl/heap_priority_queue_if.sv
// -----------------------------------------------------------------------------
// heap_priority_queue_if
//   Command / observation bundle for heap_priority_queue.
//
//   enable       command qualifier (0 = hold all state)
//   operation    5-bit command code: 0 NOP, 1 INSERT, 2 EXTRACT, 3 REPLACE,
//                4..31 NOP
//   input_value  key for INSERT / REPLACE
//   heap_array   flattened storage, slot i = [i*WIDTH +: WIDTH], slot 0 = root
//   heap_size    number of valid keys
//   full/empty   occupancy flags
//   error        one-cycle pulse after an illegal command
//
//   master: the side issuing commands; slave: the heap itself.
// -----------------------------------------------------------------------------
interface heap_priority_queue_if #(
    parameter int WIDTH  = 32,
    parameter int SIZE_W = 5
);
    logic                          enable;
    logic [4:0]                    operation;
    logic [WIDTH-1:0]              input_value;
    logic [(2**SIZE_W)*WIDTH-1:0]  heap_array;
    logic [SIZE_W-1:0]             heap_size;
    logic                          full;
    logic                          empty;
    logic                          error;

    modport master (
        output enable, operation, input_value,
        input  heap_array, heap_size, full, empty, error
    );

    modport slave (
        input  enable, operation, input_value,
        output heap_array, heap_size, full, empty, error
    );
endinterface

// File: rtl/heap_priority_queue.sv
// -----------------------------------------------------------------------------
// heap_priority_queue
//   Binary heap priority queue holding up to 2**SIZE_W-1 unsigned keys. Every
//   enabled cycle executes one command (INSERT, EXTRACT, REPLACE) completely:
//   sift-up and sift-down are unrolled combinationally over all tree levels, so
//   the result is visible one clock after the command edge.
//
//   Build option: define HEAP_MAX_EN for a max-heap (largest key at the root);
//   left undefined the block is a min-heap. Flags and errors are the same in
//   both builds.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (clears every slot, size and error)
//   bus    heap_priority_queue_if.slave: enable, operation, input_value in;
//          heap_array, heap_size, full, empty, error out
// -----------------------------------------------------------------------------
module heap_priority_queue #(
    parameter int WIDTH  = 32,
    parameter int SIZE_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    heap_priority_queue_if.slave  bus
);
    localparam int                SLOTS      = 2**SIZE_W;
    localparam logic [SIZE_W-1:0] CAPACITY   = '1;
    localparam logic [4:0]        OP_INSERT  = 5'd1;
    localparam logic [4:0]        OP_EXTRACT = 5'd2;
    localparam logic [4:0]        OP_REPLACE = 5'd3;

    logic [WIDTH-1:0]  heap_reg  [SLOTS];
    logic [WIDTH-1:0]  heap_next [SLOTS];
    logic [SIZE_W-1:0] size_reg, size_next;
    logic              error_reg, error_next;

    // Working variables of the unrolled sift networks.
    logic              do_insert;
    logic              do_sift_down;
    logic [SIZE_W-1:0] last_idx;
    logic [SIZE_W-1:0] up_idx, up_par;
    logic              up_done;
    logic [SIZE_W-1:0] dn_idx, dn_c;
    logic [SIZE_W:0]   dn_l, dn_r;     // one extra bit: children of slot 30 are 61/62
    logic              dn_done;
    logic [WIDTH-1:0]  tmp;

    // True when key a belongs above key b in the tree.
    function automatic logic above(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef HEAP_MAX_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    always_comb begin
        heap_next    = heap_reg;
        size_next    = size_reg;
        error_next   = 1'b0;
        do_insert    = 1'b0;
        do_sift_down = 1'b0;
        last_idx     = size_reg - 1'b1;
        up_idx       = size_reg;
        up_par       = '0;
        up_done      = 1'b0;
        dn_idx       = '0;
        dn_c         = '0;
        dn_l         = '0;
        dn_r         = '0;
        dn_done      = 1'b0;
        tmp          = '0;

        if (bus.enable) begin
            case (bus.operation)
                OP_INSERT: begin
                    if (size_reg == CAPACITY) error_next = 1'b1;
                    else                      do_insert  = 1'b1;
                end
                OP_EXTRACT: begin
                    if (size_reg == '0) begin
                        error_next = 1'b1;
                    end else begin
                        // With a single key the clear below overwrites the
                        // move, leaving the root at 0 as required.
                        heap_next[0]        = heap_reg[last_idx];
                        heap_next[last_idx] = '0;
                        size_next           = last_idx;
                        do_sift_down        = 1'b1;
                    end
                end
                OP_REPLACE: begin
                    if (size_reg == '0) begin
                        do_insert = 1'b1;
                    end else begin
                        heap_next[0] = bus.input_value;
                        do_sift_down = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // Sift-up: new key enters at the first free slot and climbs while it
        // strictly beats its parent; equal keys stay put.
        if (do_insert) begin
            heap_next[size_reg] = bus.input_value;
            size_next           = size_reg + 1'b1;
            for (int lvl = 0; lvl < SIZE_W; lvl++) begin
                if (!up_done && up_idx != '0) begin
                    up_par = (up_idx - 1'b1) >> 1;
                    if (above(heap_next[up_idx], heap_next[up_par])) begin
                        tmp               = heap_next[up_idx];
                        heap_next[up_idx] = heap_next[up_par];
                        heap_next[up_par] = tmp;
                        up_idx            = up_par;
                    end else begin
                        up_done = 1'b1;
                    end
                end
            end
        end

        // Sift-down from the root over the new occupancy. Only children below
        // size_next are considered; the left child wins a tie.
        if (do_sift_down) begin
            for (int lvl = 0; lvl < SIZE_W - 1; lvl++) begin
                if (!dn_done) begin
                    dn_l = ({1'b0, dn_idx} << 1) + 1'b1;
                    dn_r = dn_l + 1'b1;
                    if (dn_l >= {1'b0, size_next}) begin
                        dn_done = 1'b1;
                    end else begin
                        dn_c = dn_l[SIZE_W-1:0];
                        if (dn_r < {1'b0, size_next} &&
                            above(heap_next[dn_r[SIZE_W-1:0]], heap_next[dn_l[SIZE_W-1:0]]))
                            dn_c = dn_r[SIZE_W-1:0];
                        if (above(heap_next[dn_c], heap_next[dn_idx])) begin
                            tmp               = heap_next[dn_c];
                            heap_next[dn_c]   = heap_next[dn_idx];
                            heap_next[dn_idx] = tmp;
                            dn_idx            = dn_c;
                        end else begin
                            dn_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++) heap_reg[i] <= '0;
            size_reg  <= '0;
            error_reg <= 1'b0;
        end else begin
            heap_reg  <= heap_next;
            size_reg  <= size_next;
            error_reg <= error_next;
        end
    end

    // Flatten storage for observation.
    wire [SLOTS*WIDTH-1:0] heap_flat;
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_flat
        assign heap_flat[gi*WIDTH +: WIDTH] = heap_reg[gi];
    end

    assign bus.heap_array = heap_flat;
    assign bus.heap_size  = size_reg;
    assign bus.full       = (size_reg == CAPACITY);
    assign bus.empty      = (size_reg == '0);
    assign bus.error      = error_reg;
endmodule

// File: tb/tb_heap_priority_queue.sv
// -----------------------------------------------------------------------------
// tb_heap_priority_queue
//   Directed stimulus for heap_priority_queue. A reference heap kept as a plain
//   array is updated from the same commands and compared with the DUT on every
//   falling edge; literal expectations pin the reference at key points.
//   Define HEAP_MAX_EN for both DUT and bench to exercise the max-heap build.
// -----------------------------------------------------------------------------
module tb_heap_priority_queue;
    localparam int W     = 32;
    localparam int SW    = 5;
    localparam int SLOTS = 32;
    localparam int CAP   = 31;

    localparam logic [4:0] NOP = 5'd0, INS = 5'd1, EXT = 5'd2, REP = 5'd3;

    logic clk;
    logic rst_n = 1'b0;
    bit   chk_on = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    heap_priority_queue_if #(.WIDTH(W), .SIZE_W(SW)) bus();

    heap_priority_queue #(.WIDTH(W), .SIZE_W(SW)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [W-1:0] m [SLOTS];
    int           m_size = 0;
    bit           m_err  = 1'b0;

    function automatic bit m_above(logic [W-1:0] a, logic [W-1:0] b);
`ifdef HEAP_MAX_EN
        return a > b;
`else
        return a < b;
`endif
    endfunction

    task automatic m_swap(int a, int b);
        logic [W-1:0] t;
        t = m[a]; m[a] = m[b]; m[b] = t;
    endtask

    task automatic m_insert(logic [W-1:0] v);
        int i;
        i = m_size;
        m[i] = v;
        m_size++;
        while (i > 0 && m_above(m[i], m[(i - 1) / 2])) begin
            m_swap(i, (i - 1) / 2);
            i = (i - 1) / 2;
        end
    endtask

    task automatic m_sift_down();
        int i, c;
        i = 0;
        while (2 * i + 1 < m_size) begin
            c = 2 * i + 1;
            if (c + 1 < m_size && m_above(m[c + 1], m[c])) c = c + 1;
            if (!m_above(m[c], m[i])) break;
            m_swap(i, c);
            i = c;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SLOTS; i++) m[i] = '0;
            m_size = 0;
            m_err  = 1'b0;
        end else begin
            m_err = 1'b0;
            if (bus.enable) begin
                case (bus.operation)
                    INS: if (m_size == CAP) m_err = 1'b1; else m_insert(bus.input_value);
                    EXT: begin
                        if (m_size == 0) m_err = 1'b1;
                        else begin
                            m[0] = m[m_size - 1];
                            m[m_size - 1] = '0;
                            m_size--;
                            m_sift_down();
                        end
                    end
                    REP: begin
                        if (m_size == 0) m_insert(bus.input_value);
                        else begin
                            m[0] = bus.input_value;
                            m_sift_down();
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] slot(int i);
        return bus.heap_array[i*W +: W];
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            int bad;
            bad = -1;
            chk("model heap_size", W'(bus.heap_size), W'(m_size));
            chk("model full",  W'(bus.full),  W'(m_size == CAP));
            chk("model empty", W'(bus.empty), W'(m_size == 0));
            chk("model error", W'(bus.error), W'(m_err));
            for (int i = 0; i < SLOTS; i++)
                if (bad < 0 && slot(i) !== m[i]) bad = i;
            if (bad < 0) chk("model heap_array", slot(0), m[0]);
            else         chk($sformatf("model heap_array slot %0d", bad), slot(bad), m[bad]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic cmd(logic [4:0] op, logic [W-1:0] v);
        @(negedge clk);
        bus.enable      = 1'b1;
        bus.operation   = op;
        bus.input_value = v;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            bus.enable    = 1'b0;
            bus.operation = NOP;
        end
    endtask

    task automatic chk_slots(string name, logic [W-1:0] e0, logic [W-1:0] e1,
                             logic [W-1:0] e2, logic [W-1:0] e3, logic [W-1:0] e4);
        chk({name, " slot0"}, slot(0), e0);
        chk({name, " slot1"}, slot(1), e1);
        chk({name, " slot2"}, slot(2), e2);
        chk({name, " slot3"}, slot(3), e3);
        chk({name, " slot4"}, slot(4), e4);
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.operation   = NOP;
        bus.input_value = '0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        chk_on = 1'b1;

        // Reset mid-stream, asserted while an INSERT is set up.
        cmd(INS, 7); cmd(INS, 3); cmd(INS, 9);
        cmd(INS, 11);
        #2 rst_n = 1'b0;
        bus.enable = 1'b0;
        idle(2);
        chk("reset heap_size", W'(bus.heap_size), 0);
        chk("reset empty", W'(bus.empty), 1);
        chk("reset error", W'(bus.error), 0);
        chk("reset array ones", W'($countones(bus.heap_array)), 0);
        #2 rst_n = 1'b1;
        idle(1);
        chk("post-reset heap_size", W'(bus.heap_size), 0);

        cmd(INS, 15); cmd(INS, 10); cmd(INS, 20); cmd(INS, 5); cmd(INS, 30);
        idle(1);
`ifdef HEAP_MAX_EN
        chk_slots("insert5", 30, 20, 15, 5, 10);
`else
        chk_slots("insert5", 5, 10, 20, 15, 30);
`endif
        chk("insert5 heap_size", W'(bus.heap_size), 5);

        cmd(EXT, 0);
        idle(1);
`ifdef HEAP_MAX_EN
        chk_slots("extract", 20, 10, 15, 5, 0);
`else
        chk_slots("extract", 10, 15, 20, 30, 0);
`endif
        chk("extract heap_size", W'(bus.heap_size), 4);

        cmd(REP, 30);
        idle(6);
`ifdef HEAP_MAX_EN
        chk_slots("replace+hold", 30, 10, 15, 5, 0);
`else
        chk_slots("replace+hold", 15, 30, 20, 30, 0);
`endif
        chk("replace+hold heap_size", W'(bus.heap_size), 4);
        chk("hold error", W'(bus.error), 0);

        // Drain, then EXTRACT on empty: one-cycle error pulse.
        repeat (4) cmd(EXT, 0);
        cmd(EXT, 0);
        cmd(NOP, 0);
        chk("empty-extract error", W'(bus.error), 1);
        chk("empty-extract heap_size", W'(bus.heap_size), 0);
        idle(1);
        chk("empty-extract error clears", W'(bus.error), 0);

        // REPLACE on empty acts as INSERT without error.
        cmd(REP, 42);
        idle(1);
        chk("replace-empty slot0", slot(0), 42);
        chk("replace-empty heap_size", W'(bus.heap_size), 1);
        chk("replace-empty error", W'(bus.error), 0);
        cmd(EXT, 0);

        // Fill with 31 keys (duplicates included), then overflow.
        for (int i = 0; i < CAP; i++) cmd(INS, W'((i * 37) % 23));
        idle(1);
        chk("fill full", W'(bus.full), 1);
        chk("fill heap_size", W'(bus.heap_size), 31);
`ifdef HEAP_MAX_EN
        chk("fill root", slot(0), 22);
`else
        chk("fill root", slot(0), 0);
`endif
        cmd(INS, 1);
        idle(1);
        chk("overflow error", W'(bus.error), 1);
        chk("overflow full", W'(bus.full), 1);
        chk("overflow heap_size", W'(bus.heap_size), 31);

        // Reserved codes are NOPs even with enable high.
        cmd(NOP, 5); cmd(5'd4, 5); cmd(5'd31, 5);
        idle(1);
        chk("reserved-op heap_size", W'(bus.heap_size), 31);

        // Mixed REPLACE / EXTRACT traffic, then drain past empty.
        for (int i = 0; i < 20; i++) begin
            if (i % 3 != 2) cmd(REP, W'((i * 53) % 41));
            else            cmd(EXT, 0);
        end
        for (int i = 0; i < 32; i++) cmd(EXT, 0);
        idle(2);
        chk("final empty", W'(bus.empty), 1);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
